// File: rtl/spi_slave_if.sv
// Bus-side bundle of the SPI target: transmit buffer load,
// receive register / DMA pop and status pulses.
interface spi_slave_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       dma_request;
  logic       dma_ack;
  logic       rx_overrun;
  logic       tx_underrun;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  dma_request,
    output dma_ack,
    input  rx_overrun,
    input  tx_underrun
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output dma_request,
    input  dma_ack,
    output rx_overrun,
    output tx_underrun
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 target with oversampled pins, 1-entry rx/tx buffers.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first bit order.
module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  spi_slave_if.slave bus
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sclk_q, cs_q, mosi_q;
  logic sclk_d, cs_d;

  logic [2:0] bit_cnt;
  logic [7:0] rx_sr, tx_sr, tx_buf;
  logic [7:0] rx_next, tx_shift;
  logic [7:0] rx_data_r;
  logic       tx_full, rx_valid_r;
  logic       overrun_r, underrun_r;

  logic rise, fall, cs_fall, cs_rise;
  logic load, byte_done;

  assign sclk_q = sclk_sync[SYNC_STAGES-1];
  assign cs_q   = cs_sync[SYNC_STAGES-1];
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  // sclk edges only count while selected
  assign rise    = sclk_q & ~sclk_d & ~cs_q;
  assign fall    = ~sclk_q & sclk_d & ~cs_q;
  assign cs_fall = ~cs_q & cs_d;
  assign cs_rise = cs_q & ~cs_d;

  assign load      = cs_fall | (fall & (bit_cnt == 3'd0));
  assign byte_done = rise & (bit_cnt == 3'd7);

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next  = {mosi_q, rx_sr[7:1]};
  assign tx_shift = {1'b0, tx_sr[7:1]};
  assign miso     = tx_sr[0];
`else
  assign rx_next  = {rx_sr[6:0], mosi_q};
  assign tx_shift = {tx_sr[6:0], 1'b0};
  assign miso     = tx_sr[7];
`endif

  assign miso_oe          = ~cs_q;
  assign bus.tx_ready     = ~tx_full;
  assign bus.rx_data      = rx_data_r;
  assign bus.rx_valid     = rx_valid_r;
  assign bus.dma_request  = rx_valid_r;
  assign bus.rx_overrun   = overrun_r;
  assign bus.tx_underrun  = underrun_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync  <= '0;
      cs_sync    <= '1;
      mosi_sync  <= '0;
      sclk_d     <= 1'b0;
      cs_d       <= 1'b1;
      bit_cnt    <= 3'd0;
      rx_sr      <= 8'h00;
      tx_sr      <= 8'h00;
      tx_buf     <= 8'h00;
      tx_full    <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_q;
      cs_d      <= cs_q;
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;

      if (bus.tx_valid && !tx_full) begin
        tx_buf  <= bus.tx_data;
        tx_full <= 1'b1;
      end

      // a load only ever consumes a byte that was already buffered
      if (load) begin
        if (tx_full) begin
          tx_sr   <= tx_buf;
          tx_full <= 1'b0;
        end else begin
          tx_sr      <= IDLE_BYTE;
          underrun_r <= 1'b1;
        end
      end else if (fall) begin
        tx_sr <= tx_shift;
      end

      if (cs_fall || cs_rise) begin
        bit_cnt <= 3'd0;
        rx_sr   <= 8'h00;
      end else if (rise) begin
        rx_sr   <= rx_next;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (bus.dma_ack)
        rx_valid_r <= 1'b0;

      if (byte_done) begin
        if (!rx_valid_r || bus.dma_ack) begin
          rx_data_r  <= rx_next;
          rx_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as SPI master and DMA/bus side.
// Follows SPI_SLAVE_LSB_FIRST_EN like the design.
module tb_spi_slave;

  localparam int HALF = 50;
`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe;

  spi_slave_if bus ();

  spi_slave dut (
    .clk     (clk),
    .reset   (reset),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;
  int und_n = 0;
  int ovr_n = 0;

  always @(posedge clk) begin
    if (bus.tx_underrun === 1'b1) und_n <= und_n + 1;
    if (bus.rx_overrun === 1'b1)  ovr_n <= ovr_n + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic ack();
    bus.dma_ack = 1'b1;
    @(negedge clk);
    bus.dma_ack = 1'b0;
  endtask

  // Master transfer; wb holds miso bits in wire order.
  task automatic xfer(input logic [7:0] tx,
                      input int nbits,
                      input bit ack_last,
                      output logic [7:0] rx,
                      output logic [7:0] wb);
    int b;
    rx = 8'h00;
    wb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      b = LSB ? i : 7 - i;
      mosi = tx[b];
      #HALF;
      sclk = 1'b1;
      rx[b] = miso;
      wb[i] = miso;
      if (ack_last && i == nbits - 1) begin
        // lands on the cycle the rise is detected
        #20 bus.dma_ack = 1'b1;
        #10 bus.dma_ack = 1'b0;
        #(HALF - 30);
      end else begin
        #HALF;
      end
      sclk = 1'b0;
    end
    #HALF;
  endtask

  logic [7:0] r, w;
  int u0, o0;

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.dma_ack  = 1'b0;

    cyc(3);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_dma_req", bus.dma_request, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    reset = 1'b1;
    cyc(3);

    // receive A5
    cs_n = 1'b0;
    cyc(10);
    check("oe_selected", miso_oe, 1);
    xfer(8'hA5, 8, 1'b0, r, w);
    cyc(6);
    check("rx_a5_data", bus.rx_data, 8'hA5);
    check("rx_a5_dreq", bus.dma_request, 1);
    ack();
    check("ack_clears", bus.dma_request, 0);
    cs_n = 1'b1;
    cyc(6);
    check("oe_deselect", miso_oe, 0);

    // transmit 3C then idle byte
    wr_tx(8'h3C);
    check("tx_ready_full", bus.tx_ready, 0);
    u0 = und_n;
    cs_n = 1'b0;
    cyc(10);
    check("tx_ready_at_s", bus.tx_ready, 1);
    check("no_und_at_s", und_n - u0, 0);
    u0 = und_n;
    xfer(8'h00, 8, 1'b0, r, w);
    cyc(6);
    check("tx_3c", r, 8'h3C);
    check("und_once", und_n - u0, 1);
    xfer(8'h00, 8, 1'b0, r, w);
    cyc(6);
    check("tx_idle", r, 8'hFF);
    cs_n = 1'b1;
    cyc(6);
    ack();

    // overrun without ack
    check("ovr_pre_empty", bus.rx_valid, 0);
    cs_n = 1'b0;
    cyc(10);
    o0 = ovr_n;
    xfer(8'h11, 8, 1'b0, r, w);
    xfer(8'h22, 8, 1'b0, r, w);
    cyc(6);
    check("ovr_keep_11", bus.rx_data, 8'h11);
    check("ovr_pulse", ovr_n - o0, 1);
    check("ovr_valid", bus.rx_valid, 1);
    cs_n = 1'b1;
    cyc(6);
    ack();

    // coincident ack on second byte
    cs_n = 1'b0;
    cyc(10);
    o0 = ovr_n;
    xfer(8'h11, 8, 1'b0, r, w);
    xfer(8'h22, 8, 1'b1, r, w);
    cyc(6);
    check("ack_co_data", bus.rx_data, 8'h22);
    check("ack_co_valid", bus.rx_valid, 1);
    check("ack_co_noovr", ovr_n - o0, 0);
    cs_n = 1'b1;
    cyc(6);
    ack();

    // sclk ignored while deselected
    xfer(8'h77, 8, 1'b0, r, w);
    cyc(6);
    check("desel_ignore", bus.rx_valid, 0);

    // chip-select abort
    cs_n = 1'b0;
    cyc(10);
    xfer(8'hF0, 5, 1'b0, r, w);
    cs_n = 1'b1;
    cyc(10);
    check("abort_drop", bus.rx_valid, 0);
    cs_n = 1'b0;
    cyc(10);
    xfer(8'h0F, 8, 1'b0, r, w);
    cyc(6);
    check("abort_0f", bus.rx_data, 8'h0F);
    check("abort_valid", bus.rx_valid, 1);

    // reset mid-byte
    wr_tx(8'h99);
    check("rm_tx_full", bus.tx_ready, 0);
    xfer(8'h00, 3, 1'b0, r, w);
    check("rm_miso_pre", miso, 1);
    reset = 1'b0;
    #1;
    check("rm_miso", miso, 0);
    check("rm_oe", miso_oe, 0);
    check("rm_tx_ready", bus.tx_ready, 1);
    check("rm_rx_valid", bus.rx_valid, 0);
    check("rm_dreq", bus.dma_request, 0);
    check("rm_rx_data", bus.rx_data, 0);
    check("rm_ovr", bus.rx_overrun, 0);
    check("rm_und", bus.tx_underrun, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(10);
    xfer(8'h5A, 8, 1'b0, r, w);
    cyc(6);
    check("rm_5a", bus.rx_data, 8'h5A);
    check("rm_5a_valid", bus.rx_valid, 1);
    check("rm_tx_idle", r, 8'hFF);
    cs_n = 1'b1;
    cyc(6);
    ack();

`ifdef SPI_SLAVE_LSB_FIRST_EN
    cs_n = 1'b0;
    cyc(10);
    xfer(8'h01, 8, 1'b0, r, w);
    cyc(6);
    check("lsb_rx_01", bus.rx_data, 8'h01);
    cs_n = 1'b1;
    cyc(6);
    ack();
    wr_tx(8'h80);
    cs_n = 1'b0;
    cyc(10);
    xfer(8'h00, 8, 1'b0, r, w);
    cyc(6);
    check("lsb_first_bit", w[0], 0);
    check("lsb_last_bit", w[7], 1);
    check("lsb_tx_80", r, 8'h80);
    cs_n = 1'b1;
    cyc(6);
`else
    wr_tx(8'h80);
    cs_n = 1'b0;
    cyc(10);
    xfer(8'h00, 8, 1'b0, r, w);
    cyc(6);
    check("msb_first_bit", w[0], 1);
    check("msb_last_bit", w[7], 0);
    cs_n = 1'b1;
    cyc(6);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 target (slave) port: the other end of the byte-wide SPI link, letting an external SPI master read and write the SoC. It oversamples `sclk`/`cs_n`/`mosi` in the system clock domain and deserialises received bytes into a one-entry receive register. That register raises `dma_request` toward the DMA controller, which pops it with `dma_ack`. A one-entry transmit buffer is loaded from the bus side and shifted out on `miso`.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth for `sclk`, `cs_n` and `mosi` (range 2..3).
- `IDLE_BYTE`, default 8'hFF: byte shifted out when the transmit buffer is empty at a byte load.
- `clk` input 1: system clock; must be at least 4× the `sclk` frequency.
- `reset` input 1: asynchronous, active-low reset.
- `sclk` input 1: SPI clock from the master; idles low (CPOL=0).
- `cs_n` input 1: SPI chip select, active low.
- `mosi` input 1: master-out data.
- `miso` output 1: slave-out data.
- `miso_oe` output 1: `miso` drive enable; high while synchronised `cs_n` is low.
- `tx_data` input 8: byte to transmit.
- `tx_valid` input 1: `tx_data` offered.
- `tx_ready` output 1: transmit buffer empty.
- `rx_data` output 8: last received byte; held stable while `rx_valid`=1.
- `rx_valid` output 1: receive register full.
- `dma_request` output 1: equal to `rx_valid`.
- `dma_ack` input 1: pops the receive register.
- `rx_overrun` output 1: one-cycle pulse when a received byte is dropped.
- `tx_underrun` output 1: one-cycle pulse when `IDLE_BYTE` is loaded instead of buffered data.

## Operation
- **Edge detection.** Edges are detected on the synchronised signals only: `sclk` rise (R), `sclk` fall (F), `cs_n` fall (S), `cs_n` rise (E).
- **Transmit buffer.** A `tx_valid && tx_ready` cycle writes `tx_data` into the buffer and clears `tx_ready` the next cycle. The buffer empties (`tx_ready`=1) when its byte is loaded into the tx shift register.
- **S.** Clear `bit_cnt`, clear the rx shift register, and load the tx shift register: buffer byte if full, else `IDLE_BYTE` plus a `tx_underrun` pulse.
- **R.** Shift synchronised `mosi` into the rx shift register (MSB first). Increment the 3-bit `bit_cnt`, which wraps 7→0.
- **R with `bit_cnt`=7 (byte complete).**
  - If `rx_valid`=0, or `dma_ack`=1 in the same cycle: write the assembled byte to `rx_data` and set `rx_valid`.
  - Otherwise: drop the byte, keep `rx_data` unchanged, and pulse `rx_overrun`.
- **F.** If `bit_cnt`≠0, shift the tx register left. If `bit_cnt`=0 (byte boundary), load the next byte exactly as at S.
- **`miso`.** Always equals tx shift register bit 7.
- **`dma_ack`.** `dma_ack` with `rx_valid`=1 clears `rx_valid` the next cycle. `dma_ack` with `rx_valid`=0 is ignored.
- **E mid-byte.** Clear `bit_cnt` and discard the partial rx byte. A tx byte already loaded is consumed and is not returned to the buffer. `rx_data`/`rx_valid` and the buffer are unaffected.
- **Edges while `cs_n` high.** `sclk` edges are ignored.
- **Reset assertion (any time).** Immediately forces:
  - `miso`=0, `miso_oe`=0, `tx_ready`=1;
  - `rx_valid`=0, `dma_request`=0, `rx_data`=8'h00;
  - `rx_overrun`=0, `tx_underrun`=0;
  - `bit_cnt`=0, both shift registers cleared, transmit buffer empty.

## Timing
- **Input latency.** `SYNC_STAGES` cycles of synchroniser delay, plus one edge-detect register. All actions occur on the cycle the detected edge is registered.
- **Receive latency.** `rx_valid`/`dma_request` rise 1 cycle after the detected 8th R.
- **`dma_ack` latency.** `rx_valid` falls 1 cycle after `dma_ack`.
- **Transmit setup.** `miso` for bit 0 is valid 1 cycle after S. The master must allow at least `SYNC_STAGES`+2 `clk` cycles between the `cs_n` fall and the first `sclk` rise.
- **Byte-boundary load.** The next byte loads on the detected 8th F. The buffer must be written before that edge to avoid underrun.
- **Status pulses.** `rx_overrun` and `tx_underrun` are single-cycle, registered.

## Configuration
- **`SPI_SLAVE_LSB_FIRST_EN` defined.** Both directions are LSB first:
  - rx shifts in at bit 7 and shifts right;
  - `miso` = tx bit 0;
  - tx shifts right.
- **Not defined.** MSB first, as described under Operation.

## Test plan
- **Receive.** Reset, `cs_n` low, master sends 8'hA5 → `rx_data`=8'hA5 and `dma_request`=1 one cycle after the 8th detected R. `dma_ack` → `dma_request`=0 next cycle.
- **Transmit.** Write `tx_data`=8'h3C before `cs_n` falls, master clocks 8 bits → master captures 8'h3C and `tx_ready` returns to 1 at S. Second byte with no buffer write → master captures 8'hFF and `tx_underrun` pulses once.
- **Overrun.** Send 8'h11 then 8'h22 with no `dma_ack` → `rx_data` stays 8'h11 and `rx_overrun` pulses once. Repeat with `dma_ack` coincident with the 2nd byte's 8th R → `rx_data`=8'h22, no pulse.
- **Chip-select abort.** Raise `cs_n` after 5 bits of 8'hF0, then send full 8'h0F → only 8'h0F is received and `bit_cnt` restarts at 0.
- **Reset mid-byte.** Assert `reset` low after 3 bits → all outputs take their reset values within the same cycle, and the next full byte 8'h5A is received correctly.
- **LSB-first build.** With `SPI_SLAVE_LSB_FIRST_EN`, master sends wire sequence 1,0,0,0,0,0,0,0 → `rx_data`=8'h01. `tx_data`=8'h80 → first `miso` bit 0, last bit 1.
